// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//   Shares one SPI master between two byte-sequencing controllers. Ownership
//   is granted for a whole CS frame (as long as the owner holds its req level),
//   arbitrated round-robin on ties. The owner's start/MOSI/CS_END are forwarded
//   to the master through registers (1-cycle latency); busy/MISO are returned
//   to the owner only. A quiet owner (req high, no start, master idle) is
//   forcibly released after TIMEOUT cycles, with a one-cycle timeout_err pulse.
//   Every release passes through a single RELEASE cycle holding CS high.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   reqN_req/start/mosi/cs_end requester N frame request and byte interface
//   reqN_grant                 requester N owns the bus (registered)
//   reqN_busy                  spi_busy | spi_start when granted, else 1
//   reqN_miso                  spi_miso when granted, else 0
//   spi_start/mosi/cs_end      registered byte interface to the SPI master
//   spi_busy, spi_miso         status/data back from the SPI master
//   timeout_err                one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_req,
  input  logic              req0_start,
  input  logic [DATA_W-1:0] req0_mosi,
  input  logic              req0_cs_end,
  output logic              req0_grant,
  output logic              req0_busy,
  output logic [DATA_W-1:0] req0_miso,

  input  logic              req1_req,
  input  logic              req1_start,
  input  logic [DATA_W-1:0] req1_mosi,
  input  logic              req1_cs_end,
  output logic              req1_grant,
  output logic              req1_busy,
  output logic [DATA_W-1:0] req1_miso,

  output logic              spi_start,
  output logic [DATA_W-1:0] spi_mosi,
  output logic              spi_cs_end,
  input  logic              spi_busy,
  input  logic [DATA_W-1:0] spi_miso,

  output logic              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT0,
    S_GRANT1,
    S_RELEASE
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_q;
  logic              last_q;
  logic              grant0_q;
  logic              grant1_q;
  logic              spi_start_q;
  logic [DATA_W-1:0] spi_mosi_q;
  logic              spi_cs_end_q;
  logic              timeout_err_q;
  logic [TO_W-1:0]   cnt_q;
  logic [TO_W-1:0]   cnt_d;

  // Signals of whichever requester currently owns the bus.
  logic              own_req;
  logic              own_start;
  logic [DATA_W-1:0] own_mosi;
  logic              own_cs_end;
  logic              own_quiet;
  logic              norm_rel;
  logic              to_hit;

  always_comb begin
    own_req    = req0_req;
    own_start  = req0_start;
    own_mosi   = req0_mosi;
    own_cs_end = req0_cs_end;
    if (state_q == S_GRANT1) begin
      own_req    = req1_req;
      own_start  = req1_start;
      own_mosi   = req1_mosi;
      own_cs_end = req1_cs_end;
    end
  end

  // Quiet: master idle and no start either pending in the register or arriving.
  assign own_quiet = !spi_busy && !spi_start_q && !own_start;
  // Normal release waits for any byte in flight (registered start or busy).
  assign norm_rel  = !own_req && !spi_busy && !spi_start_q;
  assign to_hit    = own_req && own_quiet && (cnt_q == TO_LAST);
  // Counter runs only over consecutive quiet cycles with req held.
  assign cnt_d     = (own_req && own_quiet) ? cnt_q + TO_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_q        <= 1'b1;
      grant0_q      <= 1'b0;
      grant1_q      <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_mosi_q    <= '0;
      spi_cs_end_q  <= 1'b1;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          spi_start_q  <= 1'b0;
          spi_cs_end_q <= 1'b1;
          cnt_q        <= '0;
          // On a tie req0 wins only if req1 was the last owner.
          if (req0_req && (!req1_req || last_q)) begin
            state_q  <= S_GRANT0;
            grant0_q <= 1'b1;
            last_q   <= 1'b0;
          end else if (req1_req) begin
            state_q  <= S_GRANT1;
            grant1_q <= 1'b1;
            last_q   <= 1'b1;
          end
        end
        S_GRANT0, S_GRANT1: begin
          if (norm_rel || to_hit) begin
            state_q       <= S_RELEASE;
            grant0_q      <= 1'b0;
            grant1_q      <= 1'b0;
            spi_start_q   <= 1'b0;
            spi_cs_end_q  <= 1'b1;
            cnt_q         <= '0;
            timeout_err_q <= to_hit;
          end else begin
            spi_start_q  <= own_start;
            spi_mosi_q   <= own_mosi;
            spi_cs_end_q <= own_cs_end;
            cnt_q        <= cnt_d;
          end
        end
        S_RELEASE: begin
          state_q      <= S_IDLE;
          spi_start_q  <= 1'b0;
          spi_cs_end_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_grant  = grant0_q;
  assign req1_grant  = grant1_q;
  assign req0_busy   = grant0_q ? (spi_busy | spi_start_q) : 1'b1;
  assign req1_busy   = grant1_q ? (spi_busy | spi_start_q) : 1'b1;
  assign req0_miso   = grant0_q ? spi_miso : '0;
  assign req1_miso   = grant1_q ? spi_miso : '0;
  assign spi_start   = spi_start_q;
  assign spi_mosi    = spi_mosi_q;
  assign spi_cs_end  = spi_cs_end_q;
  assign timeout_err = timeout_err_q;

endmodule
